// File: rtl/tt_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tt_chk_pkg
//  Brief    : Shared types and constants for the truth-table checker.
//  Revision : 1.0 - initial release
// ============================================================================
package tt_chk_pkg;

    // Checker FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int         VEC_W    = 4;
    localparam int         N_VEC    = 16;
    localparam logic [3:0] LAST_VEC = 4'd15;
    localparam int         ERR_W    = 5;
    localparam int         TMR_W    = $clog2(256);

    // Golden {y,z,f2} for one vector, picked out of the three truth tables
    function automatic logic [2:0] expected_resp(
        input logic [N_VEC-1:0] tbl_y,
        input logic [N_VEC-1:0] tbl_z,
        input logic [N_VEC-1:0] tbl_f2,
        input logic [VEC_W-1:0] vec
    );
        return {tbl_y[vec], tbl_z[vec], tbl_f2[vec]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tt_settle_timer
//  Brief    : Loadable down-counter that flags when the settle time expired.
//  Revision : 1.0 - initial release
// ============================================================================
module tt_settle_timer
    import tt_chk_pkg::*;
#(
    parameter int WIDTH = TMR_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load takes priority; otherwise count down while enabled, parking at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : truth_table_checker
//  Brief    : Walks a 4-input combinational block through vectors 0..15,
//             compares {y,z,f2} against golden tables and reports results.
//  Options  : define TT_FAIL_MAP_EN to add the 16-bit fail_map output.
//  Revision : 1.0 - initial release
// ============================================================================
module truth_table_checker
    import tt_chk_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXP_Y         = 16'h0000,
    parameter logic [15:0] EXP_Z         = 16'h0000,
    parameter logic [15:0] EXP_F2        = 16'h0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    input  logic             y,
    input  logic             z,
    input  logic             f2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_fail_valid,
    output logic [VEC_W-1:0] first_fail_idx
`ifdef TT_FAIL_MAP_EN
    ,
    output logic [N_VEC-1:0] fail_map
`endif
);

    // The timer holds SETTLE_CYCLES-1 so that SETTLE lasts SETTLE_CYCLES cycles
    localparam logic [TMR_W-1:0] c_SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [VEC_W-1:0] r_vec;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic             r_ffv;
    logic [VEC_W-1:0] r_ffi;
`ifdef TT_FAIL_MAP_EN
    logic [N_VEC-1:0] r_fail_map;
`endif

    logic             w_accept;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tmr_zero;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    // A start is only honoured while no run is in progress
    assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && start;
    // Reload on a new run and on every step to the next vector
    assign w_tmr_load = w_accept || ((r_state == CHECK) && (r_vec != LAST_VEC));
    assign w_tmr_en   = (r_state == SETTLE);
    assign w_mismatch = ({y, z, f2} != expected_resp(EXP_Y, EXP_Z, EXP_F2, r_vec));
    assign w_err_next = r_err + ERR_W'(w_mismatch);

    tt_settle_timer #(
        .WIDTH (TMR_W)
    ) u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_en       (w_tmr_en),
        .i_load_val (c_SETTLE_LOAD),
        .o_zero     (w_tmr_zero)
    );

    // Checker FSM with all status outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= '0;
            r_ffv      <= 1'b0;
            r_ffi      <= '0;
`ifdef TT_FAIL_MAP_EN
            r_fail_map <= '0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state    <= SETTLE;
                        r_vec      <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_err      <= '0;
                        r_ffv      <= 1'b0;
                        r_ffi      <= '0;
`ifdef TT_FAIL_MAP_EN
                        r_fail_map <= '0;
`endif
                    end
                end
                SETTLE: begin
                    if (w_tmr_zero) begin
                        r_state <= CHECK;
                    end
                end
                CHECK: begin
                    r_err <= w_err_next;
                    if (w_mismatch) begin
`ifdef TT_FAIL_MAP_EN
                        r_fail_map[r_vec] <= 1'b1;
`endif
                        if (!r_ffv) begin
                            r_ffv <= 1'b1;
                            r_ffi <= r_vec;
                        end
                    end
                    // The last vector never wraps: it only leads to DONE
                    if (r_vec == LAST_VEC) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == '0);
                    end else begin
                        r_vec   <= r_vec + VEC_W'(1);
                        r_state <= SETTLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign {a, b, c, d}     = r_vec;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_count        = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_idx   = r_ffi;
`ifdef TT_FAIL_MAP_EN
    assign fail_map         = r_fail_map;
`endif

endmodule
`default_nettype wire

// File: tb/tb_truth_table_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_truth_table_checker
//  Brief    : Self-checking bench for truth_table_checker (SETTLE_CYCLES=2
//             and SETTLE_CYCLES=1 instances) driven by a model DUT.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_truth_table_checker;

    localparam int M_GOLD   = 0;  // AND / OR / XOR model
    localparam int M_F15    = 1;  // y forced 0 on vector 15
    localparam int M_STUCK1 = 2;  // all responses tied to 1
    localparam int M_STUCK0 = 3;  // all responses tied to 0
    localparam int M_GLITCH = 4;  // y inverted in the cycle after a vector change

    logic clk = 1'b0;
    logic rst;
    logic start0, start1;

    logic       a0, b0, c0, d0, y0, z0, f20, busy0, done0, pass0, ffv0;
    logic [4:0] err0;
    logic [3:0] ffi0;
    logic       a1, b1, c1, d1, y1, z1, f21, busy1, done1, pass1, ffv1;
    logic [4:0] err1;
    logic [3:0] ffi1;
`ifdef TT_FAIL_MAP_EN
    logic [15:0] map0, map1;
`endif

    int mode0 = M_GOLD;
    int mode1 = M_GOLD;
    int cur   = 0;
    int tests = 0;
    int fails = 0;
    int sb_q[$];

    logic [3:0] vec0, vec1, prev0, prev1;
    assign vec0 = {a0, b0, c0, d0};
    assign vec1 = {a1, b1, c1, d1};

    always #5 clk = ~clk;

    // Model of the block under test
    function automatic logic [2:0] model_resp(input int mode, input logic [3:0] v,
                                              input logic changed);
        logic [2:0] g;
        g = {&v, |v, ^v};
        case (mode)
            M_F15:    return (v == 4'd15) ? {1'b0, g[1:0]} : g;
            M_STUCK1: return 3'b111;
            M_STUCK0: return 3'b000;
            M_GLITCH: return changed ? {~g[2], g[1:0]} : g;
            default:  return g;
        endcase
    endfunction

    always @(posedge clk) begin
        prev0 <= vec0;
        prev1 <= vec1;
    end

    always_comb {y0, z0, f20} = model_resp(mode0, vec0, vec0 != prev0);
    always_comb {y1, z1, f21} = model_resp(mode1, vec1, vec1 != prev1);

    truth_table_checker #(
        .SETTLE_CYCLES (2), .EXP_Y (16'h8000), .EXP_Z (16'hFFFE), .EXP_F2 (16'h6996)
    ) dut (
        .clk (clk), .rst (rst), .start (start0),
        .a (a0), .b (b0), .c (c0), .d (d0),
        .y (y0), .z (z0), .f2 (f20),
        .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
        .first_fail_valid (ffv0), .first_fail_idx (ffi0)
`ifdef TT_FAIL_MAP_EN
        , .fail_map (map0)
`endif
    );

    truth_table_checker #(
        .SETTLE_CYCLES (1), .EXP_Y (16'h8000), .EXP_Z (16'hFFFE), .EXP_F2 (16'h6996)
    ) dut1 (
        .clk (clk), .rst (rst), .start (start1),
        .a (a1), .b (b1), .c (c1), .d (d1),
        .y (y1), .z (z1), .f2 (f21),
        .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
        .first_fail_valid (ffv1), .first_fail_idx (ffi1)
`ifdef TT_FAIL_MAP_EN
        , .fail_map (map1)
`endif
    );

    // Status of whichever instance is currently exercised
    logic [3:0] s_vec, s_ffi;
    logic [4:0] s_err;
    logic       s_busy, s_done, s_pass, s_ffv;
    always_comb begin
        s_vec  = (cur == 0) ? vec0  : vec1;
        s_ffi  = (cur == 0) ? ffi0  : ffi1;
        s_err  = (cur == 0) ? err0  : err1;
        s_busy = (cur == 0) ? busy0 : busy1;
        s_done = (cur == 0) ? done0 : done1;
        s_pass = (cur == 0) ? pass0 : pass1;
        s_ffv  = (cur == 0) ? ffv0  : ffv1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One run: expected vector sequence queued at start, popped as vectors appear.
    // poke >= 0 pulses start again when that vector is being driven.
    task automatic run_vec(input int poke, output int cycles);
        int  last;
        bit  poked;
        last  = -1;
        poked = 1'b0;
        for (int i = 0; i < 16; i++) sb_q.push_back(i);
        @(negedge clk);
        if (cur == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        check("done_cleared", {31'd0, s_done}, 0);
        check("err_cleared", {27'd0, s_err}, 0);
        check("busy_set", {31'd0, s_busy}, 1);
        cycles = 0;
        while (!s_done && cycles < 200) begin
            if (s_busy && int'(s_vec) != last) begin
                last = int'(s_vec);
                check("vec_seq", {28'd0, s_vec}, (sb_q.size() != 0) ? sb_q.pop_front() : 99);
            end
            if (!poked && poke == int'(s_vec)) begin
                if (cur == 0) start0 = 1'b1; else start1 = 1'b1;
                poked = 1'b1;
            end
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            cycles++;
        end
        check("sb_drained", sb_q.size(), 0);
        sb_q.delete();
    endtask

    typedef struct {
        int          sel;
        int          mode;
        int          poke;
        int          cyc;
        logic [4:0]  err;
        logic        ffv;
        logic [3:0]  ffi;
        logic        pass;
        logic [15:0] map;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int cyc;
        tbl[0] = '{0, M_GOLD,   -1, 48, 5'd0,  1'b0, 4'd0,  1'b1, 16'h0000};
        tbl[1] = '{0, M_F15,    -1, 48, 5'd1,  1'b1, 4'd15, 1'b0, 16'h8000};
        tbl[2] = '{0, M_STUCK1, -1, 48, 5'd16, 1'b1, 4'd0,  1'b0, 16'hFFFF};
        tbl[3] = '{0, M_STUCK0, -1, 48, 5'd15, 1'b1, 4'd1,  1'b0, 16'hFFFE};
        tbl[4] = '{0, M_GOLD,    5, 48, 5'd0,  1'b0, 4'd0,  1'b1, 16'h0000};
        tbl[5] = '{1, M_GOLD,   -1, 32, 5'd0,  1'b0, 4'd0,  1'b1, 16'h0000};
        tbl[6] = '{1, M_GLITCH, -1, 32, 5'd0,  1'b0, 4'd0,  1'b1, 16'h0000};
        tbl[7] = '{1, M_F15,    -1, 32, 5'd1,  1'b1, 4'd15, 1'b0, 16'h8000};

        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_dut0", {17'd0, vec0, busy0, done0, pass0, ffv0, err0, ffi0}, 0);
        check("reset_dut1", {17'd0, vec1, busy1, done1, pass1, ffv1, err1, ffi1}, 0);
        @(negedge clk); rst = 1'b0;

        // Table-driven runs, back to back so each start also restarts from DONE
        for (int i = 0; i < 8; i++) begin
            cur = tbl[i].sel;
            if (cur == 0) mode0 = tbl[i].mode; else mode1 = tbl[i].mode;
            run_vec(tbl[i].poke, cyc);
            check($sformatf("cycles[%0d]", i), cyc, tbl[i].cyc);
            check($sformatf("done[%0d]", i), {31'd0, s_done}, 1);
            check($sformatf("busy[%0d]", i), {31'd0, s_busy}, 0);
            check($sformatf("err[%0d]", i), {27'd0, s_err}, {27'd0, tbl[i].err});
            check($sformatf("ffv[%0d]", i), {31'd0, s_ffv}, {31'd0, tbl[i].ffv});
            check($sformatf("ffi[%0d]", i), {28'd0, s_ffi}, {28'd0, tbl[i].ffi});
            check($sformatf("pass[%0d]", i), {31'd0, s_pass}, {31'd0, tbl[i].pass});
`ifdef TT_FAIL_MAP_EN
            check($sformatf("map[%0d]", i), {16'd0, (cur == 0) ? map0 : map1},
                  {16'd0, tbl[i].map});
`endif
            // Outputs hold in DONE and vec stays at the last vector
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("hold_done[%0d]", i), {27'd0, s_done, s_vec}, 32'h1F);
        end

        // Reset mid-run at vector 7 while in SETTLE
        cur   = 0;
        mode0 = M_STUCK1;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        for (int i = 0; i < 100 && vec0 != 4'd7; i++) begin
            @(posedge clk); #1;
        end
        check("reach_vec7", {28'd0, vec0}, 7);
        check("err_before_rst", {27'd0, err0}, 7);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {17'd0, vec0, busy0, done0, pass0, ffv0, err0, ffi0}, 0);
        @(negedge clk); rst = 1'b0;
        mode0 = M_GOLD;
        run_vec(-1, cyc);
        check("rerun_cycles", cyc, 48);
        check("rerun_status", {23'd0, s_done, s_pass, s_ffv, s_err, s_busy}, 32'h180);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Synthesizable on-chip checker that exhaustively stimulates a 4-input/3-output combinational block and checks its responses.
- Drives a,b,c,d through vectors 0..15, waits a settle time, samples y,z,f2 and compares them against parameterized golden truth tables.
- Reports a mismatch count, the first failing vector, and pass/done status, so exercises can be self-checked on the board without a simulator.

Parameters:
- SETTLE_CYCLES, 2, cycles the drive vector is held before sampling; legal range 1..255.
- EXP_Y, 16'h0000, golden truth table for y; bit index = vector value.
- EXP_Z, 16'h0000, golden truth table for z.
- EXP_F2, 16'h0000, golden truth table for f2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- a  out  1  vector bit 3 (MSB).
- b  out  1  vector bit 2.
- c  out  1  vector bit 1.
- d  out  1  vector bit 0 (LSB).
- y  in  1  DUT response y.
- z  in  1  DUT response z.
- f2  in  1  DUT response f2.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high after the final vector is checked, until the next start or rst.
- pass  out  1  equals done AND err_count==0.
- err_count  out  5  number of failing vectors, 0..16.
- first_fail_valid  out  1  high once any mismatch has been recorded.
- first_fail_idx  out  4  vector value of the first mismatch.

Behaviour:
- Reset (asynchronous, any state, including mid-run):
  - state=IDLE; vec=0.
  - a,b,c,d = 0.
  - busy, done, pass, first_fail_valid = 0.
  - err_count = 0; first_fail_idx = 0.
- Vector mapping: {a,b,c,d} = vec[3:0], all four outputs registered.
  - Expected response for a vector = {EXP_Y[vec], EXP_Z[vec], EXP_F2[vec]}.
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - When start=1: clear err_count, first_fail_*, done; set vec=0; load the settle counter with SETTLE_CYCLES-1; go to SETTLE; busy=1.
- SETTLE:
  - Hold vec. Decrement the counter; when it reaches 0, go to CHECK.
  - Total time in SETTLE is exactly SETTLE_CYCLES cycles.
- CHECK (exactly 1 cycle), at its clock edge:
  - Compare the sampled {y,z,f2} against the expected value.
  - On mismatch: err_count += 1. If first_fail_valid=0, set first_fail_valid=1 and first_fail_idx=vec.
  - If vec==15: go to DONE; busy=0; done=1.
  - Otherwise: vec += 1, reload the counter, go to SETTLE.
- Run timing:
  - Per-vector time is SETTLE_CYCLES+1 cycles.
  - done rises 16*(SETTLE_CYCLES+1) cycles after the edge that sampled start (48 cycles at the default).
- DONE:
  - Outputs hold, and vec stays at 15.
  - start=1 restarts exactly as from IDLE.
- start while busy is ignored.
- The vector counter never wraps during a run: the transition out of vec==15 goes only to DONE.
- Inputs y,z,f2 are sampled only in CHECK; changes during SETTLE have no effect.
- err_count is 5 bits, so the maximum value 16 cannot overflow.

Optional Feature:
- Macro: TT_FAIL_MAP_EN.
- When defined: extra output port fail_map, 16 bits, out.
  - Bit vec is set in CHECK on a mismatch.
  - Cleared by rst and by an accepted start.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package tt_chk_pkg:
  - State enum (IDLE, SETTLE, CHECK, DONE).
  - VEC_W=4, N_VEC=16, LAST_VEC=4'd15, ERR_W=5.
- One sub-module, tt_settle_timer:
  - Loadable down-counter of width $clog2(256).
  - Inputs load and en; output zero flag.
  - Used by the FSM in SETTLE.

Test Plan:
- Golden DUT: EXP_Y=16'h8000 (4-input AND), EXP_Z=16'hFFFE (OR), EXP_F2=16'h6996 (XOR), matching a model DUT; start pulse -> a,b,c,d step through 0..15, done=1 at cycle 48, pass=1, err_count=0, first_fail_valid=0.
- Fault injection: force y=0 on vector 15 only -> err_count=1, first_fail_idx=15, pass=0; with TT_FAIL_MAP_EN defined, fail_map=16'h8000.
- Stuck DUT: y,z,f2 tied to 1 -> err_count equals the number of vectors with any expected 0 (16 for the golden tables above); first_fail_idx=0.
- Reset mid-run: assert rst at vector 7 in SETTLE -> all outputs 0 immediately (asynchronous); a following start reruns from vec=0 with counts cleared.
- Start while busy plus restart: pulse start at vector 5 -> ignored (no change in vec sequence); after done, pulse start -> done=0 next cycle, err_count cleared, new run completes in 48 cycles.
- SETTLE_CYCLES=1: with the golden DUT -> done at cycle 32; y changing during SETTLE but correct in CHECK -> no error counted.
